// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: memory op codes, access sizes, FSM states and
// the write-back result record.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LD_B     = 4'd1,
        LD_BU    = 4'd2,
        LD_H     = 4'd3,
        LD_HU    = 4'd4,
        LD_W     = 4'd5,
        ST_B     = 4'd6,
        ST_H     = 4'd7,
        ST_W     = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
    } wb_res_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane handling for the MEM stage: store strobes and lane replication,
// load byte/half selection with sign/zero extension, and the misalign check.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        is_load,
    output logic        is_store,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    mem_op_e     op_e;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign op_e  = mem_op_e'(op);
    assign rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        rbyte = rdata[7:0];
        case (addr_lo)
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            2'd3:    rbyte = rdata[31:24];
            default: rbyte = rdata[7:0];
        endcase
    end

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        size      = SIZE_W;
        wstrb     = 4'b0000;
        wdata     = store_data;
        load_data = rdata;
        case (op_e)
            LD_B:  begin is_load = 1'b1; size = SIZE_B; load_data = {{24{rbyte[7]}}, rbyte}; end
            LD_BU: begin is_load = 1'b1; size = SIZE_B; load_data = {24'h0, rbyte}; end
            LD_H:  begin is_load = 1'b1; size = SIZE_H; load_data = {{16{rhalf[15]}}, rhalf}; end
            LD_HU: begin is_load = 1'b1; size = SIZE_H; load_data = {16'h0, rhalf}; end
            LD_W:  begin is_load = 1'b1; size = SIZE_W; end
            ST_B: begin
                is_store = 1'b1;
                size     = SIZE_B;
                wstrb    = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
            end
            ST_H: begin
                is_store = 1'b1;
                size     = SIZE_H;
                wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{store_data[15:0]}};
            end
            ST_W: begin
                is_store = 1'b1;
                size     = SIZE_W;
                wstrb    = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        if (is_load || is_store) begin
            case (size)
                SIZE_H:  misalign = addr_lo[0];
                SIZE_W:  misalign = |addr_lo;
                default: misalign = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs loads/stores over the data SRAM req/addr_ok/data_ok
// handshake, stalls the front of the pipe while busy, holds results for MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [4:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              we_i,
    input  logic              flush_i,
    input  logic              stall_down_i,
    output logic              stallreq_o,
    output logic              ale_o,
    output logic [4:0]        waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata
);

    state_e            state, state_nxt;
    wb_res_t           hold_q, res;
    logic              capture, hold_clr, done;
    logic              is_load, is_store, misalign, is_mem;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [DATA_W-1:0] wdata_rep, load_data;
    logic              req, stall, ale, r_we;
    logic [4:0]        r_waddr;
    logic [DATA_W-1:0] r_wdata;

    mem_align u_align (
        .op         (mem_op_i),
        .addr_lo    (mem_addr_i[1:0]),
        .store_data (store_data_i),
        .rdata      (data_sram_rdata),
        .is_load    (is_load),
        .is_store   (is_store),
        .size       (size),
        .wstrb      (wstrb),
        .wdata      (wdata_rep),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    assign is_mem    = valid_i & (is_load | is_store);
    assign res.waddr = waddr_i;
    assign res.wdata = is_load ? load_data : wdata_i;
    assign res.we    = we_i & is_load;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        hold_clr  = 1'b0;
        done      = 1'b0;
        req       = 1'b0;
        stall     = 1'b0;
        ale       = 1'b0;
        r_waddr   = waddr_i;
        r_wdata   = wdata_i;
        r_we      = we_i;
        case (state)
            S_IDLE, S_REQ: begin
                if (state == S_IDLE && is_mem) begin
                    r_we = 1'b0;
                    ale  = misalign & ~flush_i;
                end
                // An IDLE issue behaves as REQ in the same cycle, so an
                // immediate addr_ok is not lost.
                if (state == S_REQ || (is_mem && !flush_i && !misalign)) begin
                    req   = 1'b1;
                    stall = ~flush_i;
                    r_we  = 1'b0;
                    if (data_sram_addr_ok) begin
                        if (flush_i)
                            state_nxt = data_sram_data_ok ? S_IDLE : S_DRAIN;
                        else if (data_sram_data_ok)
                            done = 1'b1;
                        else
                            state_nxt = S_WAIT;
                    end else begin
                        state_nxt = flush_i ? S_IDLE : S_REQ;
                    end
                end
            end
            S_WAIT: begin
                stall = ~flush_i;
                r_we  = 1'b0;
                if (data_sram_data_ok) begin
                    if (flush_i) state_nxt = S_IDLE;
                    else         done = 1'b1;
                end else if (flush_i) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_HOLD: begin
                r_waddr = hold_q.waddr;
                r_wdata = hold_q.wdata;
                r_we    = 1'b0;
                stall   = 1'b1;
                if (flush_i) begin
                    hold_clr  = 1'b1;
                    stall     = 1'b0;
                    state_nxt = S_IDLE;
                end else if (!stall_down_i) begin
                    r_we      = hold_q.we;
                    stall     = 1'b0;
                    hold_clr  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Abandoned access still in flight: nothing is written back and
                // a newly arrived instruction waits until the bus is free.
                r_we  = 1'b0;
                stall = valid_i & ~flush_i;
                if (data_sram_data_ok) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (done) begin
            if (stall_down_i) begin
                capture   = 1'b1;
                stall     = 1'b1;
                r_we      = 1'b0;
                state_nxt = S_HOLD;
            end else begin
                r_wdata   = res.wdata;
                r_we      = res.we;
                stall     = 1'b0;
                state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            hold_q <= '0;
        end else begin
            state <= state_nxt;
            if (capture)       hold_q <= res;
            else if (hold_clr) hold_q <= '0;
        end
    end

    assign stallreq_o      = ~rst & stall;
    assign ale_o           = ~rst & ale;
    assign we_o            = ~rst & r_we;
    assign waddr_o         = rst ? NOPRegAddr : r_waddr;
    assign wdata_o         = rst ? ZeroWord : r_wdata;
    assign data_sram_req   = ~rst & req;
    assign data_sram_wr    = ~rst & is_store;
    assign data_sram_size  = rst ? 2'b00 : size;
    assign data_sram_wstrb = rst ? 4'b0000 : wstrb;
    assign data_sram_addr  = rst ? '0 : mem_addr_i;
    assign data_sram_wdata = rst ? '0 : wdata_rep;

endmodule
